// File: rtl/mem_stage_hs_if.sv
// mem_stage_hs_if: data-memory request/response bus between the handshaked
// memory stage and a variable-latency data memory.
//
// Signals:
//   dmem_req_valid / dmem_req_ready  request handshake (stage -> memory)
//   dmem_req_wr                      1 = write, 0 = read
//   dmem_req_addr                    byte address
//   dmem_req_wdata / dmem_req_wstrb  lane-aligned store data and byte strobes
//   dmem_rsp_valid                   one response beat per accepted request
//   dmem_rsp_rdata / dmem_rsp_err    read data and fault flag
//
// Modports: master = memory stage, slave = data memory.
interface mem_stage_hs_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  localparam int STRB_W = DATA_W / 8;

  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_req_wr;
  logic [ADDR_W-1:0] dmem_req_addr;
  logic [DATA_W-1:0] dmem_req_wdata;
  logic [STRB_W-1:0] dmem_req_wstrb;
  logic              dmem_rsp_valid;
  logic [DATA_W-1:0] dmem_rsp_rdata;
  logic              dmem_rsp_err;

  modport master (
    output dmem_req_valid, dmem_req_wr, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata, dmem_rsp_err
  );

  modport slave (
    input  dmem_req_valid, dmem_req_wr, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata, dmem_rsp_err
  );
endinterface

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: handshaked pipeline memory stage between IX/MEM and MEM/WB.
// Non-memory ops and misaligned accesses pass to MEM/WB in one cycle; aligned
// loads/stores are captured into hold registers, issued on the dmem bus
// (IDLE -> REQ -> WAIT) and completed on response or after TIMEOUT cycles of
// waiting. Upstream is stalled while an access is outstanding.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   *_ixmem_p1               stage inputs (valid, ldst, strobes, addr, data,
//                            ALU value, dest index, writeback request)
//   stall_mem_p1             combinational upstream hold
//   dmem                     data-memory bus (master side)
//   *_memwb_p1               registered MEM/WB outputs, valid is a 1-cycle pulse
module mem_stage_hs #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int REG_IDX_W = 3,
  parameter int TIMEOUT   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_ixmem_p1,
  input  logic                   ldst_valid_ixmem_p1,
  input  logic [DATA_W/8-1:0]    store_strb_ixmem_p1,
  input  logic [ADDR_W-1:0]      mem_addr_ixmem_p1,
  input  logic [DATA_W-1:0]      mem_data_in_ixmem_p1,
  input  logic [DATA_W-1:0]      dest_reg_value_ixmem_p1,
  input  logic [REG_IDX_W-1:0]   dest_reg_index_ixmem_p1,
  input  logic                   dest_reg_write_valid_ixmem_p1,
  output logic                   stall_mem_p1,
  mem_stage_hs_if.master         dmem,
  output logic                   valid_memwb_p1,
  output logic [DATA_W-1:0]      dest_reg_value_memwb_p1,
  output logic [REG_IDX_W-1:0]   dest_reg_index_memwb_p1,
  output logic                   dest_reg_write_valid_memwb_p1,
  output logic                   mem_err_memwb_p1
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LSB_W  = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    wdata;
    logic [STRB_W-1:0]    strb;
    logic [DATA_W-1:0]    value;
    logic [REG_IDX_W-1:0] idx;
    logic                 wv;
  } hold_t;

  typedef struct packed {
    logic                 valid;
    logic [DATA_W-1:0]    value;
    logic [REG_IDX_W-1:0] idx;
    logic                 wv;
    logic                 err;
  } wb_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hold_t            hold_q, hold_d;
  wb_t              wb_q, wb_d;

  logic in_is_load;
  logic in_misaligned;
  logic hold_is_load;

  // Partial stores are allowed at any byte offset; only full-width accesses
  // (loads and all-strobe stores) must be word aligned.
  assign in_is_load    = ~|store_strb_ixmem_p1;
  assign in_misaligned = (in_is_load | (&store_strb_ixmem_p1)) &&
                         (mem_addr_ixmem_p1[LSB_W-1:0] != '0);
  assign hold_is_load  = ~|hold_q.strb;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    wb_d         = wb_q;
    wb_d.valid   = 1'b0;
    stall_mem_p1 = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (valid_ixmem_p1) begin
          if (!ldst_valid_ixmem_p1 || in_misaligned) begin
            wb_d.valid = 1'b1;
            wb_d.value = dest_reg_value_ixmem_p1;
            wb_d.idx   = dest_reg_index_ixmem_p1;
            wb_d.wv    = dest_reg_write_valid_ixmem_p1 & ~ldst_valid_ixmem_p1;
            wb_d.err   = ldst_valid_ixmem_p1;
          end else begin
            hold_d.addr  = mem_addr_ixmem_p1;
            hold_d.wdata = mem_data_in_ixmem_p1;
            hold_d.strb  = store_strb_ixmem_p1;
            hold_d.value = dest_reg_value_ixmem_p1;
            hold_d.idx   = dest_reg_index_ixmem_p1;
            hold_d.wv    = dest_reg_write_valid_ixmem_p1;
            state_d      = S_REQ;
            stall_mem_p1 = 1'b1;
          end
        end
      end

      S_REQ: begin
        stall_mem_p1 = 1'b1;
        if (dmem.dmem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end

      S_WAIT: begin
        if (dmem.dmem_rsp_valid) begin
          wb_d.valid = 1'b1;
          wb_d.value = hold_is_load ? dmem.dmem_rsp_rdata : hold_q.value;
          wb_d.idx   = hold_q.idx;
          wb_d.wv    = hold_q.wv & ~dmem.dmem_rsp_err;
          wb_d.err   = dmem.dmem_rsp_err;
          state_d    = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Forced completion; any response arriving later lands in IDLE
          // or REQ and is ignored there.
          wb_d.valid = 1'b1;
          wb_d.value = hold_q.value;
          wb_d.idx   = hold_q.idx;
          wb_d.wv    = 1'b0;
          wb_d.err   = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d        = cnt_q + CNT_W'(1);
          stall_mem_p1 = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      wb_q    <= wb_d;
    end
  end

  // Request payload comes only from the hold registers, so it stays stable
  // for as long as the memory withholds ready.
  assign dmem.dmem_req_valid = (state_q == S_REQ);
  assign dmem.dmem_req_wr    = |hold_q.strb;
  assign dmem.dmem_req_addr  = hold_q.addr;
  assign dmem.dmem_req_wdata = hold_q.wdata;
  assign dmem.dmem_req_wstrb = hold_q.strb;

  assign valid_memwb_p1                = wb_q.valid;
  assign dest_reg_value_memwb_p1       = wb_q.value;
  assign dest_reg_index_memwb_p1       = wb_q.idx;
  assign dest_reg_write_valid_memwb_p1 = wb_q.wv;
  assign mem_err_memwb_p1              = wb_q.err;
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: self-checking bench for mem_stage_hs. Each operation is
// described by its fields plus the memory's behaviour (ready delay, response
// delay, read data, error); expected bus activity, stall pattern, latency and
// MEM/WB results are derived from the stage's rules for that operation.
module tb_mem_stage_hs;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int REG_IDX_W = 3;
  localparam int TIMEOUT   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, ldst_in, wv_in;
  logic [1:0]  strb_in;
  logic [15:0] addr_in, wdata_in, value_in;
  logic [2:0]  idx_in;
  logic        stall;
  logic        wb_valid, wb_wv, wb_err;
  logic [15:0] wb_value;
  logic [2:0]  wb_idx;

  int checks = 0;
  int errors = 0;

  // Per-iteration random op description.
  int          r_kind;
  logic        r_ldst;
  logic [1:0]  r_strb;
  logic [15:0] r_addr;

  mem_stage_hs_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dmem_bus ();

  mem_stage_hs #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_IDX_W(REG_IDX_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk                           (clk),
    .rst                           (rst),
    .valid_ixmem_p1                (valid_in),
    .ldst_valid_ixmem_p1           (ldst_in),
    .store_strb_ixmem_p1           (strb_in),
    .mem_addr_ixmem_p1             (addr_in),
    .mem_data_in_ixmem_p1          (wdata_in),
    .dest_reg_value_ixmem_p1       (value_in),
    .dest_reg_index_ixmem_p1       (idx_in),
    .dest_reg_write_valid_ixmem_p1 (wv_in),
    .stall_mem_p1                  (stall),
    .dmem                          (dmem_bus),
    .valid_memwb_p1                (wb_valid),
    .dest_reg_value_memwb_p1       (wb_value),
    .dest_reg_index_memwb_p1       (wb_idx),
    .dest_reg_write_valid_memwb_p1 (wb_wv),
    .mem_err_memwb_p1              (wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    valid_in = 1'($urandom);
    ldst_in  = 1'($urandom);
    strb_in  = 2'($urandom);
    addr_in  = 16'($urandom);
    wdata_in = 16'($urandom);
    value_in = 16'($urandom);
    idx_in   = 3'($urandom);
    wv_in    = 1'($urandom);
  endtask

  task automatic idle_inputs();
    scramble_inputs();
    valid_in = 1'b0;
  endtask

  task automatic junk_rsp();
    dmem_bus.dmem_rsp_valid = 1'($urandom);
    dmem_bus.dmem_rsp_rdata = 16'($urandom);
    dmem_bus.dmem_rsp_err   = 1'($urandom);
    dmem_bus.dmem_req_ready = 1'($urandom);
  endtask

  task automatic tick_idle(input string tag);
    idle_inputs();
    @(posedge clk); @(negedge clk); #1;
    check({tag, "/no_pulse"}, 32'(wb_valid), 0);
    check({tag, "/no_req"}, 32'(dmem_bus.dmem_req_valid), 0);
  endtask

  // Called at a clock low phase with the stage idle; returns at the low
  // phase in which the result is visible on MEM/WB. d_rsp >= TIMEOUT means
  // the memory never answers.
  task automatic do_op(input string tag, input logic ldst, input logic [1:0] strb,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] value, input logic [2:0] idx, input logic wv,
                       input int d_rdy, input int d_rsp,
                       input logic [15:0] rdata, input logic rerr);
    logic is_load, misal, is_mem, timed_out, hit, chk_value;
    logic [15:0] exp_value;
    logic exp_wv, exp_err;

    is_load   = (strb == 2'b00);
    misal     = ldst && (is_load || strb == 2'b11) && addr[0];
    is_mem    = ldst && !misal;
    timed_out = is_mem && (d_rsp >= TIMEOUT);
    chk_value = !misal && !timed_out;
    exp_value = (is_mem && is_load) ? rdata : value;
    exp_err   = misal || timed_out || (is_mem && rerr);
    exp_wv    = wv && !exp_err && !misal;

    valid_in = 1'b1; ldst_in = ldst; strb_in = strb; addr_in = addr;
    wdata_in = wdata; value_in = value; idx_in = idx; wv_in = wv;
    junk_rsp();
    #1;
    check({tag, "/stall_idle"}, 32'(stall), 32'(is_mem));
    check({tag, "/idle_no_req"}, 32'(dmem_bus.dmem_req_valid), 0);
    @(posedge clk); @(negedge clk);

    if (is_mem) begin
      for (int k = 0; k <= d_rdy; k++) begin
        scramble_inputs();
        junk_rsp();
        dmem_bus.dmem_req_ready = (k == d_rdy);
        #1;
        check({tag, "/req_valid"}, 32'(dmem_bus.dmem_req_valid), 1);
        check({tag, "/req_wr"}, 32'(dmem_bus.dmem_req_wr), 32'(!is_load));
        check({tag, "/req_addr"}, 32'(dmem_bus.dmem_req_addr), 32'(addr));
        check({tag, "/req_wdata"}, 32'(dmem_bus.dmem_req_wdata), 32'(wdata));
        check({tag, "/req_wstrb"}, 32'(dmem_bus.dmem_req_wstrb), 32'(strb));
        check({tag, "/stall_req"}, 32'(stall), 1);
        check({tag, "/wb_quiet_req"}, 32'(wb_valid), 0);
        @(posedge clk); @(negedge clk);
      end
      for (int j = 0; j < TIMEOUT; j++) begin
        scramble_inputs();
        hit = !timed_out && (j == d_rsp);
        dmem_bus.dmem_req_ready = 1'($urandom);
        dmem_bus.dmem_rsp_valid = hit;
        dmem_bus.dmem_rsp_rdata = hit ? rdata : 16'($urandom);
        dmem_bus.dmem_rsp_err   = hit ? rerr : 1'($urandom);
        #1;
        check({tag, "/wait_no_req"}, 32'(dmem_bus.dmem_req_valid), 0);
        check({tag, "/stall_wait"}, 32'(stall), 32'(!(hit || j == TIMEOUT - 1)));
        check({tag, "/wb_quiet_wait"}, 32'(wb_valid), 0);
        @(posedge clk); @(negedge clk);
        if (hit) break;
      end
    end

    idle_inputs();
    junk_rsp();
    #1;
    check({tag, "/wb_valid"}, 32'(wb_valid), 1);
    if (chk_value) check({tag, "/wb_value"}, 32'(wb_value), 32'(exp_value));
    check({tag, "/wb_idx"}, 32'(wb_idx), 32'(idx));
    check({tag, "/wb_wv"}, 32'(wb_wv), 32'(exp_wv));
    check({tag, "/wb_err"}, 32'(wb_err), 32'(exp_err));
    check({tag, "/done_no_req"}, 32'(dmem_bus.dmem_req_valid), 0);
  endtask

  initial begin
    // Reset state.
    rst = 1'b0;
    idle_inputs();
    dmem_bus.dmem_req_ready = 1'b0;
    dmem_bus.dmem_rsp_valid = 1'b0;
    dmem_bus.dmem_rsp_rdata = '0;
    dmem_bus.dmem_rsp_err   = 1'b0;
    #1;
    check("rst/wb_valid", 32'(wb_valid), 0);
    check("rst/wb_value", 32'(wb_value), 0);
    check("rst/wb_idx", 32'(wb_idx), 0);
    check("rst/wb_wv", 32'(wb_wv), 0);
    check("rst/wb_err", 32'(wb_err), 0);
    check("rst/req_valid", 32'(dmem_bus.dmem_req_valid), 0);
    check("rst/stall_idle", 32'(stall), 0);
    valid_in = 1'b1; ldst_in = 1'b1; strb_in = 2'b00; addr_in = 16'h0010;
    #1 check("rst/stall_aligned_load", 32'(stall), 1);
    addr_in = 16'h0011;
    #1 check("rst/stall_misaligned_load", 32'(stall), 0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    tick_idle("post_rst");

    // Directed cases.
    do_op("alu", 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h1234, 3'd5, 1'b1, 0, 0, 16'h0, 1'b0);
    tick_idle("alu_pulse");
    do_op("load0", 1'b1, 2'b00, 16'h0010, 16'h0000, 16'h7777, 3'd3, 1'b1, 0, 0, 16'hBEEF, 1'b0);
    do_op("bstore", 1'b1, 2'b10, 16'h0021, 16'hAB00, 16'h4321, 3'd4, 1'b1, 3, 1, 16'hFFFF, 1'b0);
    do_op("misal", 1'b1, 2'b00, 16'h0003, 16'h0000, 16'h1111, 3'd1, 1'b1, 0, 0, 16'h0, 1'b0);
    do_op("misal_st", 1'b1, 2'b11, 16'h0005, 16'hCAFE, 16'h2222, 3'd2, 1'b1, 0, 0, 16'h0, 1'b0);
    do_op("rsp_err", 1'b1, 2'b00, 16'h0030, 16'h0000, 16'h3333, 3'd7, 1'b1, 1, 2, 16'h9999, 1'b1);

    // Timeout, then a late response during an idle cycle, then a normal load.
    do_op("timeout", 1'b1, 2'b00, 16'h0040, 16'h0000, 16'h4444, 3'd6, 1'b1, 0, 99, 16'h0, 1'b0);
    idle_inputs();
    dmem_bus.dmem_rsp_valid = 1'b1;
    dmem_bus.dmem_rsp_rdata = 16'hDEAD;
    dmem_bus.dmem_rsp_err   = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    check("late_rsp/no_pulse", 32'(wb_valid), 0);
    do_op("after_to", 1'b1, 2'b00, 16'h0042, 16'h0000, 16'h0000, 3'd6, 1'b1, 1, 0, 16'h5A5A, 1'b0);

    // Reset while waiting for a response.
    valid_in = 1'b1; ldst_in = 1'b1; strb_in = 2'b00; addr_in = 16'h0050;
    value_in = 16'h0; idx_in = 3'd2; wv_in = 1'b1;
    dmem_bus.dmem_rsp_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    idle_inputs();
    dmem_bus.dmem_req_ready = 1'b1;
    #1 check("rst_mid/req_valid", 32'(dmem_bus.dmem_req_valid), 1);
    @(posedge clk); @(negedge clk);
    dmem_bus.dmem_req_ready = 1'b0;
    dmem_bus.dmem_rsp_valid = 1'b0;
    #1 check("rst_mid/stall_wait", 32'(stall), 1);
    rst = 1'b0;
    #1;
    check("rst_mid/req_valid0", 32'(dmem_bus.dmem_req_valid), 0);
    check("rst_mid/wb_valid", 32'(wb_valid), 0);
    check("rst_mid/wb_value", 32'(wb_value), 0);
    check("rst_mid/wb_idx", 32'(wb_idx), 0);
    check("rst_mid/wb_wv", 32'(wb_wv), 0);
    check("rst_mid/wb_err", 32'(wb_err), 0);
    check("rst_mid/stall", 32'(stall), 0);
    dmem_bus.dmem_rsp_valid = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    check("rst_mid/held_no_pulse", 32'(wb_valid), 0);
    dmem_bus.dmem_rsp_valid = 1'b0;
    rst = 1'b1;
    tick_idle("rst_mid_release");
    do_op("rst_reload", 1'b1, 2'b00, 16'h0050, 16'h0000, 16'h0000, 3'd2, 1'b1, 0, 1, 16'hC0DE, 1'b0);

    // Randomized back-to-back operations.
    for (int n = 0; n < 40; n++) begin
      r_kind = $urandom_range(0, 4);
      r_addr = 16'($urandom);
      r_ldst = 1'b1;
      case (r_kind)
        0:       begin r_ldst = 1'b0; r_strb = 2'($urandom); end
        1:       r_strb = 2'b00;
        2:       r_strb = 2'b11;
        3:       r_strb = 2'($urandom_range(1, 2));
        default: r_strb = 2'($urandom);
      endcase
      if (r_kind == 1 || r_kind == 2) r_addr[0] = ($urandom_range(0, 3) == 0);
      do_op($sformatf("rnd%0d", n), r_ldst, r_strb, r_addr, 16'($urandom), 16'($urandom),
            3'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 5),
            16'($urandom), ($urandom_range(0, 7) == 0));
    end
    tick_idle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
